// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the RV32I program loader: base opcodes, request
// classes and loader FSM states.
package instr_encoder_loader_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_ALUI   = 7'b0010011;
   localparam logic [6:0] OPC_ALU    = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      REQ_LW   = 3'd0,
      REQ_SW   = 3'd1,
      REQ_ALUI = 3'd2,
      REQ_ALU  = 3'd3,
      REQ_BR   = 3'd4,
      REQ_END  = 3'd5
   } req_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_TERM,
      ST_DONE
   } state_e;

   // A 13-bit immediate fits a 12-bit I/S field only when bit 12 is a pure sign copy.
   function automatic logic imm12_fits(input logic [12:0] imm);
      return imm[12] == imm[11];
   endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational mapping from a field-level request to an RV32I machine word,
// plus a flag for requests that are illegal or cannot be encoded exactly.
module instr_field_encoder
   import instr_encoder_loader_pkg::*;
(
   input  logic [2:0]  req_op,
   input  logic [4:0]  req_rd,
   input  logic [4:0]  req_rs1,
   input  logic [4:0]  req_rs2,
   input  logic [2:0]  req_funct3,
   input  logic        req_funct7b5,
   input  logic [12:0] req_imm,
   output logic [31:0] enc_word,
   output logic        enc_err,
   output logic        enc_wr,
   output logic        enc_end
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path can infer a latch.
      enc_word = '0;
      enc_err  = 1'b0;
      enc_wr   = 1'b1;
      enc_end  = 1'b0;
      case (req_op)
         REQ_LW: begin
            enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_LOAD};
            enc_err  = !imm12_fits(req_imm);
         end
         REQ_ALUI: begin
            enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_ALUI};
            enc_err  = !imm12_fits(req_imm);
         end
         REQ_SW: begin
            enc_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OPC_STORE};
            enc_err  = !imm12_fits(req_imm);
         end
         REQ_ALU: begin
            enc_word = {1'b0, req_funct7b5, 5'b0, req_rs2, req_rs1, req_funct3, req_rd, OPC_ALU};
         end
         REQ_BR: begin
            // imm[0] has no slot in the B format; a set bit is reported, then dropped.
            enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                        req_imm[4:1], req_imm[11], OPC_BRANCH};
            enc_err  = req_imm[0];
         end
         REQ_END: begin
            enc_end = 1'b1;
         end
         default: begin
            enc_wr  = 1'b0;
            enc_err = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts encoded-instruction requests, writes one word per
// cycle into instruction memory and terminates the program with a zero word.
module instr_encoder_loader
   import instr_encoder_loader_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DEPTH     = 256,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [4:0]        req_rd,
   input  logic [4:0]        req_rs1,
   input  logic [4:0]        req_rs2,
   input  logic [2:0]        req_funct3,
   input  logic              req_funct7b5,
   input  logic [12:0]       req_imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              core_hold,
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   LAST_SLOT = (ADDR_W + 1)'(BASE_ADDR + DEPTH - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                wr_pending_q, wr_pending_d;
   logic [31:0]         wr_word_q, wr_word_d;
   logic                err_q, err_d;

   logic [31:0]         enc_word;
   logic                enc_err, enc_wr, enc_end;
   logic [ADDR_W:0]     claimed;
   logic                slots_full;

   instr_field_encoder u_encoder (
      .req_op       (req_op),
      .req_rd       (req_rd),
      .req_rs1      (req_rs1),
      .req_rs2      (req_rs2),
      .req_funct3   (req_funct3),
      .req_funct7b5 (req_funct7b5),
      .req_imm      (req_imm),
      .enc_word     (enc_word),
      .enc_err      (enc_err),
      .enc_wr       (enc_wr),
      .enc_end      (enc_end)
   );

   // A registered word already owns the slot at ptr_q, so it counts toward fullness.
   assign claimed    = {1'b0, ptr_q} + {{ADDR_W{1'b0}}, wr_pending_q};
   assign slots_full = claimed >= LAST_SLOT;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      count_d      = count_q;
      wr_pending_d = 1'b0;
      wr_word_d    = wr_word_q;
      err_d        = err_q;
      req_ready    = 1'b0;

      if (wr_pending_q) begin
         ptr_d   = ptr_q + 1'b1;
         count_d = count_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
               ptr_d   = BASE;
               count_d = '0;
               err_d   = 1'b0;
            end
         end
         ST_LOAD: begin
            req_ready = !slots_full;
            if (slots_full) begin
               state_d = ST_TERM;
            end else if (req_valid) begin
               wr_pending_d = enc_wr;
               if (enc_wr) wr_word_d = enc_end ? 32'h0 : enc_word;
               if (enc_err) err_d = 1'b1;
               if (enc_end) state_d = ST_DONE;
            end
         end
         ST_TERM: begin
            // Only the last slot is left; close the program there and flag the overflow.
            wr_pending_d = 1'b1;
            wr_word_d    = 32'h0;
            err_d        = 1'b1;
            state_d      = ST_DONE;
         end
         ST_DONE: begin
            if (start && !wr_pending_q) begin
               state_d = ST_LOAD;
               ptr_d   = BASE;
               count_d = '0;
               err_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         ptr_q        <= BASE;
         count_q      <= '0;
         wr_pending_q <= 1'b0;
         wr_word_q    <= '0;
         err_q        <= 1'b0;
      end else begin
         // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         count_q      <= count_d;
         wr_pending_q <= wr_pending_d;
         wr_word_q    <= wr_word_d;
         err_q        <= err_d;
      end
   end

   assign imem_we    = wr_pending_q;
   assign imem_addr  = wr_pending_q ? ptr_q : '0;
   assign imem_wdata = wr_pending_q ? wr_word_q : '0;
   assign busy       = (state_q == ST_LOAD) || (state_q == ST_TERM) || wr_pending_q;
   assign core_hold  = busy;
   assign done       = (state_q == ST_DONE) && !wr_pending_q;
   assign err        = err_q;
   assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized bench for the program loader, checked against a field-level
// encoding model and an expected write list per session.
`timescale 1ns/1ps
module tb_instr_encoder_loader;

   localparam int ADDR_W    = 4;
   localparam int DEPTH     = 8;
   localparam int BASE_ADDR = 3;
   localparam int LAST      = BASE_ADDR + DEPTH - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [2:0]        req_op = '0;
   logic [4:0]        req_rd = '0;
   logic [4:0]        req_rs1 = '0;
   logic [4:0]        req_rs2 = '0;
   logic [2:0]        req_funct3 = '0;
   logic              req_funct7b5 = 1'b0;
   logic [12:0]       req_imm = '0;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              busy, done, err, core_hold;
   logic [ADDR_W:0]   count;

   typedef struct {
      logic [2:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic        f7;
      logic [12:0] imm;
   } req_t;

   typedef struct {
      int          addr;
      logic [31:0] word;
   } wr_t;

   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;
   wr_t  exp_q[$];
   int   write_cycles[$];
   int   exp_err;
   int   exp_count;
   int   n_acc;
   bit   truncated;

   instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
      .req_funct3(req_funct3), .req_funct7b5(req_funct7b5), .req_imm(req_imm),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .busy(busy), .done(done), .err(err), .core_hold(core_hold), .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Write monitor: every strobe must match the head of the expected list.
   always @(negedge clk) begin
      wr_t w;
      cycle++;
      if (imem_we) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", imem_we, 1'b0);
         end else begin
            w = exp_q.pop_front();
            check("write_addr", imem_addr, w.addr);
            check("write_data", imem_wdata, w.word);
            write_cycles.push_back(cycle);
         end
      end
   end

   function automatic req_t mk(input int op, input int rd, input int rs1, input int rs2,
                               input int f3, input int f7, input int imm);
      req_t r;
      r.op = 3'(op); r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
      r.f3 = 3'(f3); r.f7 = 1'(f7); r.imm = 13'(imm);
      return r;
   endfunction

   // Reference encoding built from the RV32I field positions with shifts and masks.
   function automatic logic [31:0] ref_encode(input req_t r);
      logic [31:0] i, rd, rs1, rs2, f3;
      i = 32'(signed'(r.imm));
      rd = 32'(r.rd); rs1 = 32'(r.rs1); rs2 = 32'(r.rs2); f3 = 32'(r.f3);
      case (r.op)
         3'd0: return ((i & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
         3'd2: return ((i & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
         3'd1: return (((i >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                      | ((i & 32'h1F) << 7) | 32'h23;
         3'd3: return (32'(r.f7) << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
         3'd4: return (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3F) << 25) | (rs2 << 20)
                      | (rs1 << 15) | (f3 << 12) | (((i >> 1) & 32'hF) << 8)
                      | (((i >> 11) & 32'h1) << 7) | 32'h63;
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit ref_err(input req_t r);
      int v;
      v = int'(signed'(r.imm));
      if (r.op >= 3'd6) return 1'b1;
      if (r.op == 3'd0 || r.op == 3'd1 || r.op == 3'd2) return (v < -2048) || (v > 2047);
      if (r.op == 3'd4) return r.imm[0];
      return 1'b0;
   endfunction

   // Builds the expected write list: slots fill from BASE_ADDR; once only the
   // last slot is left, no more requests are taken and a zero word closes it.
   task automatic build_model(input req_t reqs[$]);
      int  next;
      bit  ended;
      exp_q.delete();
      write_cycles.delete();
      next = BASE_ADDR; exp_err = 0; n_acc = 0; ended = 0;
      foreach (reqs[k]) begin
         if (next == LAST) break;
         n_acc++;
         if (ref_err(reqs[k])) exp_err = 1;
         if (reqs[k].op >= 3'd6) continue;
         if (reqs[k].op == 3'd5) begin
            exp_q.push_back('{next, 32'h0});
            next++;
            ended = 1;
            break;
         end
         exp_q.push_back('{next, ref_encode(reqs[k])});
         next++;
      end
      truncated = !ended;
      if (truncated) begin
         exp_q.push_back('{LAST, 32'h0});
         exp_err = 1;
      end
      exp_count = exp_q.size();
   endtask

   task automatic apply(input req_t r);
      req_op = r.op; req_rd = r.rd; req_rs1 = r.rs1; req_rs2 = r.rs2;
      req_funct3 = r.f3; req_funct7b5 = r.f7; req_imm = r.imm;
   endtask

   task automatic offer(input req_t r);
      bit ok;
      apply(r);
      req_valid = 1'b1;
      ok = 0;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (req_ready) begin
            @(posedge clk);
            #1;
            ok = 1;
            break;
         end
      end
      check("handshake_timeout", ok, 1'b1);
   endtask

   task automatic run_session(input req_t reqs[$], input bit gaps, input string name);
      bit ok;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < n_acc; k++) begin
         offer(reqs[k]);
         if (gaps && $urandom_range(0, 2) == 0) begin
            req_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      if (truncated && reqs.size() > n_acc) begin
         apply(reqs[n_acc]);
         req_valid = 1'b1;
      end else begin
         req_valid = 1'b0;
      end
      ok = 0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (done) begin ok = 1; break; end
      end
      check({name, "_done"}, ok, 1'b1);
      check({name, "_ready_after"}, req_ready, 1'b0);
      req_valid = 1'b0;
      check({name, "_all_written"}, exp_q.size(), 0);
      check({name, "_count"}, count, exp_count);
      check({name, "_err"}, err, exp_err);
      check({name, "_busy"}, busy, 1'b0);
      check({name, "_hold"}, core_hold, 1'b0);
      @(posedge clk); #1;
   endtask

   function automatic req_t rand_req();
      req_t r;
      logic [11:0] x;
      r = mk($urandom_range(0, 4), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 1), 0);
      if ($urandom_range(0, 19) == 0) r.op = 3'(6 + $urandom_range(0, 1));
      if ($urandom_range(0, 4) != 0) begin
         x = 12'($urandom);
         r.imm = {x[11], x};
         if (r.op == 3'd4) r.imm[0] = 1'b0;
      end else begin
         r.imm = 13'($urandom);
      end
      return r;
   endfunction

   initial begin
      req_t reqs[$];
      logic [31:0] spec_words [4];

      #2;
      check("rst_we", imem_we, 1'b0);
      check("rst_addr", imem_addr, 0);
      check("rst_ready", req_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_count", count, 0);
      check("rst_hold", core_hold, 1'b0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed encodings, expected words written straight from the RV32I reference values.
      spec_words[0] = 32'h00C00293; spec_words[1] = 32'h00612423;
      spec_words[2] = 32'hFE208EE3; spec_words[3] = 32'h402081B3;
      reqs = '{mk(2, 5, 0, 0, 0, 0, 12), mk(1, 0, 2, 6, 2, 0, 8),
               mk(4, 0, 1, 2, 0, 0, 13'h1FFC), mk(3, 3, 1, 2, 0, 1, 0), mk(5, 0, 0, 0, 0, 0, 0)};
      build_model(reqs);
      for (int k = 0; k < 4; k++) exp_q[k].word = spec_words[k];
      run_session(reqs, 1'b0, "directed_enc");

      // Back-to-back writes, then an illegal op that must not consume a slot.
      reqs = '{mk(2, 1, 0, 0, 0, 0, 1), mk(2, 2, 0, 0, 0, 0, 2), mk(2, 3, 0, 0, 0, 0, 3),
               mk(6, 0, 0, 0, 0, 0, 0), mk(2, 4, 0, 0, 0, 0, 4), mk(5, 0, 0, 0, 0, 0, 0)};
      build_model(reqs);
      run_session(reqs, 1'b0, "throughput");
      check("consecutive_writes", write_cycles[2] - write_cycles[0], 2);

      // Overflow: more requests than slots.
      reqs.delete();
      for (int k = 0; k < DEPTH + 2; k++) reqs.push_back(mk(2, k, 1, 0, 0, 0, k));
      reqs.push_back(mk(5, 0, 0, 0, 0, 0, 0));
      build_model(reqs);
      run_session(reqs, 1'b0, "overflow");

      // Reset while a write is pending: nothing may reach memory.
      exp_q.delete();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      offer(mk(2, 9, 9, 0, 0, 0, 99));
      #2 rst_n = 1'b0;
      #1;
      check("midrst_we", imem_we, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_hold", core_hold, 1'b0);
      check("midrst_wdata", imem_wdata, 32'h0);
      check("midrst_count", count, 0);
      req_valid = 1'b0;
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int s = 0; s < 25; s++) begin
         reqs.delete();
         for (int k = 0; k < $urandom_range(0, 10); k++) reqs.push_back(rand_req());
         reqs.push_back(mk(5, 0, 0, 0, 0, 0, 0));
         build_model(reqs);
         run_session(reqs, 1'b1, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Sequential program loader that builds RV32I machine words, the inverse of the core's opcode/funct3 control decode.
- Accepts field-level instruction requests over a valid/ready handshake.
- Encodes each request into the LW/SW/ALUI/ALU/BR formats.
- Writes one word per cycle into instruction memory.
- Holds the core (core_hold) while loading.
- Terminates the program with an all-zero word; opcode 0 is decoded by the core as PC halt.

Parameters:
ADDR_W, 8, instruction-memory word-address width
DEPTH, 256, words available to the loader (must be ≤ 2**ADDR_W)
BASE_ADDR, 0, first word address written after start

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; one clock, asynchronous, active-low (already decided)
start  in  1  begin a load session (pulse)
req_valid  in  1  request present
req_ready  out  1  loader accepts request this cycle
req_op  in  3  class: 0 LW, 1 SW, 2 ALUI, 3 ALU, 4 BR, 5 END, 6–7 illegal
req_rd  in  5  destination register
req_rs1  in  5  source register 1
req_rs2  in  5  source register 2
req_funct3  in  3  funct3 field
req_funct7b5  in  1  instr[30] for ALU class (sub/sra)
req_imm  in  13  signed immediate; I/S use [11:0], BR uses [12:1]
imem_we  out  1  instruction memory write strobe
imem_addr  out  ADDR_W  write word address
imem_wdata  out  32  encoded instruction
busy  out  1  session active (LOAD or pending write)
done  out  1  session complete, held
err  out  1  sticky error for the session
core_hold  out  1  keep core PC frozen
count  out  ADDR_W+1  words written this session, including the terminator

Behaviour:
Reset (rst_n=0, asynchronous):
- State goes to IDLE; any pending write is discarded.
- All outputs are 0; write pointer = BASE_ADDR.
FSM states: IDLE, LOAD, TERM, DONE.
- IDLE: start -> LOAD; pointer=BASE_ADDR, count=0, err=0.
- LOAD: req_ready=1. A handshake at edge N registers the encoded word, and imem_we=1 with that word/address during cycle N+1. Pointer and count increment at the end of N+1. Full throughput is one word per cycle. start is ignored.
- END accepted -> encode 32'h0 -> write -> DONE.
- Pointer reaches BASE_ADDR+DEPTH-1 while in LOAD -> req_ready=0 -> TERM.
- TERM: writes 32'h0 at the last slot, sets err=1 -> DONE.
- DONE: done=1, busy=0, core_hold=0. A start pulse restarts the session (same actions as start in IDLE) and clears done.
busy and core_hold are 1 in LOAD and TERM, and during the final pending write cycle.
Encoding, with imm = req_imm:
- LW: {imm[11:0], rs1, f3, rd, 7'b0000011}
- ALUI: {imm[11:0], rs1, f3, rd, 7'b0010011}
- SW: {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011}
- ALU: {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, 7'b0110011}
- BR: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011}
Error conditions (err is sticky):
- Illegal op (6/7): request consumed, nothing written, pointer unchanged, err=1.
- I/S class with imm[12]≠imm[11]: out of range; word written truncated, err=1.
- BR with imm[0]=1: misaligned; bit dropped, word written, err=1.

Decomposition:
Shared package:
- opcode constants LW/SW/ALUI/ALU/BR (7-bit)
- req_op class codes
- FSM state encoding
Natural sub-module: instr_field_encoder, purely combinational. Maps the request fields to {word, err_flag}; the top level holds the FSM, pointer, handshake and registers.

Test Plan:
- start; ALUI rd=5 rs1=0 f3=000 imm=12; then END -> addr0=32'h00C00293, addr1=32'h00000000, done=1, count=2, err=0.
- SW rs2=6 rs1=2 f3=010 imm=8 -> imem_wdata=32'h00612423 one cycle after the handshake.
- BR rs1=1 rs2=2 f3=000 imm=-4 (13'h1FFC) -> 32'hFE208EE3. ALU rd=3 rs1=1 rs2=2 f3=000 f7b5=1 -> 32'h402081B3.
- req_valid held 3 cycles (3 ALUI) -> imem_we high 3 consecutive cycles at addr 0,1,2. Then op=6 -> err=1, no write, next word lands at addr 3.
- DEPTH=4: 4 ALUI offered -> 3 written, then req_ready=0, 32'h0 written at addr 3, err=1, done=1, count=4.
- rst_n low mid-LOAD with a write pending -> all outputs 0 immediately, no write occurs. Next start writes from BASE_ADDR with count=0.
